// File: rtl/reg_file_scoreboard_pkg.sv
// Shared types and constants for the register file / pending-write scoreboard.
// - DATA_W   : register width
// - NUM_REGS : implemented registers R0..R14 (index 15 is the PC, held in IF)
// - CNT_W    : width of each per-register pending-writer counter
package reg_file_scoreboard_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 15;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned ADDR_W   = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_addr_t REG_PC = 4'd15;

  // True when an enabled event targets register r. The PC index never matches.
  function automatic logic addr_hit(logic en, reg_addr_t addr, reg_addr_t r);
    return en && (addr == r) && (addr != REG_PC);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Pipeline-side bundle for the register file / scoreboard.
// - WB_WB_EN/WB_Dest/WB_Value : writeback from the WB stage (also retires a writer)
// - src1..src3, rd1..rd3      : ID stage read ports
// - issue_en/issue_dest       : ID issuing a register writer
// - kill_en/kill_dest         : flush of an in-flight writer
// - haz1..haz3, sb_err        : hazard flags and sticky scoreboard error
// master = pipeline side, slave = register file.
interface reg_file_scoreboard_if;
  import reg_file_scoreboard_pkg::*;

  logic      WB_WB_EN;
  reg_addr_t WB_Dest;
  reg_data_t WB_Value;
  reg_addr_t src1;
  reg_addr_t src2;
  reg_addr_t src3;
  reg_data_t rd1;
  reg_data_t rd2;
  reg_data_t rd3;
  logic      issue_en;
  reg_addr_t issue_dest;
  logic      kill_en;
  reg_addr_t kill_dest;
  logic      haz1;
  logic      haz2;
  logic      haz3;
  logic      sb_err;

  modport master (
    output WB_WB_EN, WB_Dest, WB_Value, src1, src2, src3,
    output issue_en, issue_dest, kill_en, kill_dest,
    input  rd1, rd2, rd3, haz1, haz2, haz3, sb_err
  );

  modport slave (
    input  WB_WB_EN, WB_Dest, WB_Value, src1, src2, src3,
    input  issue_en, issue_dest, kill_en, kill_dest,
    output rd1, rd2, rd3, haz1, haz2, haz3, sb_err
  );

endinterface

// File: rtl/sb_counter.sv
// One saturating up/down pending-writer counter.
// - clk, rst : clock, asynchronous active-high reset
// - inc      : one writer issued this cycle
// - dec      : number of writers retired/killed this cycle (0..2)
// - count    : current pending count
// - err      : this cycle's update would overflow or underflow (count is clamped)
module sb_counter
  import reg_file_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic [1:0] dec,
  output cnt_t       count,
  output logic       err
);

  localparam int MaxCount = (1 << CNT_W) - 1;

  cnt_t count_q, count_d;
  int   sum;

  always_comb begin
    sum     = int'(count_q) + int'(inc) - int'(dec);
    count_d = count_q;
    err     = 1'b0;
    if (sum > MaxCount) begin
      count_d = cnt_t'(MaxCount);
      err     = 1'b1;
    end else if (sum < 0) begin
      count_d = '0;
      err     = 1'b1;
    end else begin
      count_d = cnt_t'(sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file R0..R14 with three combinational read ports and a
// per-register pending-writer scoreboard.
// - clk, rst : clock, asynchronous active-high reset
// - bus      : slave side of reg_file_scoreboard_if (writeback, reads, issue/kill,
//              hazard flags, sticky sb_err)
// Reads of index 15 return 0; a same-cycle writeback to the read index is bypassed.
// Hazards reflect counts before this cycle's update; the retiring writer is not masked
// because the bypass already supplies its value.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  reg_file_scoreboard_if.slave bus
);

  reg_data_t             regs_q [NUM_REGS];
  cnt_t                  cnt    [NUM_REGS];
  logic [NUM_REGS-1:0]   cnt_err;
  logic                  sb_err_q;
  logic                  wb_we;

  reg_addr_t             src [3];
  reg_data_t             rd  [3];
  logic      [2:0]       haz;

  assign wb_we = bus.WB_WB_EN && (bus.WB_Dest != REG_PC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      regs_q[bus.WB_Dest] <= bus.WB_Value;
    end
  end

  assign src[0] = bus.src1;
  assign src[1] = bus.src2;
  assign src[2] = bus.src3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd[p]  = '0;
      haz[p] = 1'b0;
      if (src[p] != REG_PC) begin
        haz[p] = (cnt[src[p]] != '0);
        if (bus.WB_WB_EN && (bus.WB_Dest == src[p])) begin
          rd[p] = bus.WB_Value;
        end else begin
          rd[p] = regs_q[src[p]];
        end
      end
    end
  end

  assign bus.rd1  = rd[0];
  assign bus.rd2  = rd[1];
  assign bus.rd3  = rd[2];
  assign bus.haz1 = haz[0];
  assign bus.haz2 = haz[1];
  assign bus.haz3 = haz[2];

  for (genvar r = 0; r < int'(NUM_REGS); r++) begin : g_cnt
    logic       inc;
    logic       wb_hit;
    logic       kill_hit;
    logic [1:0] dec;

    assign inc      = addr_hit(bus.issue_en, bus.issue_dest, reg_addr_t'(r));
    assign wb_hit   = addr_hit(bus.WB_WB_EN, bus.WB_Dest, reg_addr_t'(r));
    assign kill_hit = addr_hit(bus.kill_en, bus.kill_dest, reg_addr_t'(r));
    // Retire and kill to the same register both count.
    assign dec      = {1'b0, wb_hit} + {1'b0, kill_hit};

    sb_counter u_sb_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .dec   (dec),
      .count (cnt[r]),
      .err   (cnt_err[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_q | (|cnt_err);
    end
  end

  assign bus.sb_err = sb_err_q;

endmodule
